// File: rtl/cheri_dec_skid.sv
// Registered decode-to-execute handoff: 2-entry skid buffer with valid/ready on both sides,
// two-phase sequencing for multicycle ops, and flush on pipeline redirect.
module cheri_dec_skid #(
  parameter bit          CheriSBND2 = 1'b0,
  parameter int unsigned OPDW       = 36
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,

  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [OPDW-1:0] id_operator_i,
  input  logic [11:0]     id_imm12_i,
  input  logic [19:0]     id_imm20_i,
  input  logic [20:0]     id_imm21_i,
  input  logic [4:0]      id_cs2_i,
  input  logic            id_rf_we_i,
  input  logic            id_multicycle_i,

  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [OPDW-1:0] ex_operator_o,
  output logic [11:0]     ex_imm12_o,
  output logic [19:0]     ex_imm20_o,
  output logic [20:0]     ex_imm21_o,
  output logic [4:0]      ex_cs2_o,
  output logic            ex_rf_we_o,
  output logic            ex_phase_o,
  output logic            ex_last_o
);

  typedef struct packed {
    logic [OPDW-1:0] op;
    logic [11:0]     imm12;
    logic [19:0]     imm20;
    logic [20:0]     imm21;
    logic [4:0]      cs2;
    logic            rf_we;
    logic            mc;
  } entry_t;

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_e;

  entry_t head_q, head_d, skid_q, skid_d, in_entry;
  logic   head_valid_q, head_valid_d;
  logic   skid_valid_q, skid_valid_d;
  phase_e phase_q, phase_d;
  logic   mc, last, pop, accept;

  assign in_entry = '{op:    id_operator_i,
                      imm12: id_imm12_i,
                      imm20: id_imm20_i,
                      imm21: id_imm21_i,
                      cs2:   id_cs2_i,
                      rf_we: id_rf_we_i,
                      mc:    id_multicycle_i};

  // Gating with head_valid keeps stale payload from holding ex_last_o low on an empty stage.
  assign mc     = CheriSBND2 & head_valid_q & head_q.mc;
  assign last   = ~(mc & (phase_q == PH_FIRST));
  assign pop    = head_valid_q & last & ex_ready_i;
  assign accept = id_valid_i & ~skid_valid_q;

  always_comb begin
    head_d       = head_q;
    skid_d       = skid_q;
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    phase_d      = phase_q;

    if (flush_i) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      phase_d      = PH_FIRST;
    end else if (pop) begin
      // skid_valid implies id_ready_o=0, so refill from skid and accept never coincide.
      phase_d = PH_FIRST;
      if (skid_valid_q) begin
        head_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        head_d = in_entry;
      end else begin
        head_valid_d = 1'b0;
      end
    end else begin
      if (mc && (phase_q == PH_FIRST)) begin
        phase_d = PH_SECOND;
      end
      if (accept) begin
        if (!head_valid_q) begin
          head_d       = in_entry;
          head_valid_d = 1'b1;
          phase_d      = PH_FIRST;
        end else begin
          skid_d       = in_entry;
          skid_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q       <= '0;
      skid_q       <= '0;
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      phase_q      <= PH_FIRST;
    end else begin
      head_q       <= head_d;
      skid_q       <= skid_d;
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
      phase_q      <= phase_d;
    end
  end

  assign id_ready_o    = ~skid_valid_q;
  assign ex_valid_o    = head_valid_q;
  assign ex_operator_o = head_valid_q ? head_q.op    : '0;
  assign ex_imm12_o    = head_valid_q ? head_q.imm12 : '0;
  assign ex_imm20_o    = head_valid_q ? head_q.imm20 : '0;
  assign ex_imm21_o    = head_valid_q ? head_q.imm21 : '0;
  assign ex_cs2_o      = head_valid_q ? head_q.cs2   : '0;
  assign ex_rf_we_o    = head_valid_q & head_q.rf_we;
  assign ex_phase_o    = (phase_q == PH_SECOND);
  assign ex_last_o     = last;

endmodule

// File: tb/tb_cheri_dec_skid.sv
// Directed bench for cheri_dec_skid: one instance with multicycle sequencing enabled, one without.
module tb_cheri_dec_skid;

  localparam int unsigned OPDW = 36;
  localparam logic [OPDW-1:0] OP_CINC = 36'h1 << 5;
  localparam logic [OPDW-1:0] OP_CSB  = 36'h1 << 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic id_valid = 1'b0;
  logic [OPDW-1:0] id_op = '0;
  logic [11:0] id_imm12 = '0;
  logic [19:0] id_imm20 = '0;
  logic [20:0] id_imm21 = '0;
  logic [4:0] id_cs2 = '0;
  logic id_rf_we = 1'b0;
  logic id_mc = 1'b0;
  logic ex_ready = 1'b0;

  logic s1_ready, s1_valid, s1_rf_we, s1_phase, s1_last;
  logic [OPDW-1:0] s1_op;
  logic [11:0] s1_imm12;
  logic [19:0] s1_imm20;
  logic [20:0] s1_imm21;
  logic [4:0] s1_cs2;

  logic s0_ready, s0_valid, s0_rf_we, s0_phase, s0_last;
  logic [OPDW-1:0] s0_op;
  logic [11:0] s0_imm12;
  logic [19:0] s0_imm20;
  logic [20:0] s0_imm21;
  logic [4:0] s0_cs2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cheri_dec_skid #(.CheriSBND2(1'b1), .OPDW(OPDW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .id_valid_i(id_valid), .id_ready_o(s1_ready), .id_operator_i(id_op),
    .id_imm12_i(id_imm12), .id_imm20_i(id_imm20), .id_imm21_i(id_imm21),
    .id_cs2_i(id_cs2), .id_rf_we_i(id_rf_we), .id_multicycle_i(id_mc),
    .ex_valid_o(s1_valid), .ex_ready_i(ex_ready), .ex_operator_o(s1_op),
    .ex_imm12_o(s1_imm12), .ex_imm20_o(s1_imm20), .ex_imm21_o(s1_imm21),
    .ex_cs2_o(s1_cs2), .ex_rf_we_o(s1_rf_we), .ex_phase_o(s1_phase), .ex_last_o(s1_last)
  );

  cheri_dec_skid #(.CheriSBND2(1'b0), .OPDW(OPDW)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .id_valid_i(id_valid), .id_ready_o(s0_ready), .id_operator_i(id_op),
    .id_imm12_i(id_imm12), .id_imm20_i(id_imm20), .id_imm21_i(id_imm21),
    .id_cs2_i(id_cs2), .id_rf_we_i(id_rf_we), .id_multicycle_i(id_mc),
    .ex_valid_o(s0_valid), .ex_ready_i(ex_ready), .ex_operator_o(s0_op),
    .ex_imm12_o(s0_imm12), .ex_imm20_o(s0_imm20), .ex_imm21_o(s0_imm21),
    .ex_cs2_o(s0_cs2), .ex_rf_we_o(s0_rf_we), .ex_phase_o(s0_phase), .ex_last_o(s0_last)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Other payload fields are derived from imm12 so a single tag identifies an entry.
  task automatic drive(input logic v, input logic [OPDW-1:0] op, input logic [11:0] imm,
                       input logic m);
    id_valid = v;
    id_op    = op;
    id_imm12 = imm;
    id_imm20 = {imm, 8'hA5};
    id_imm21 = {imm, 9'h001};
    id_cs2   = imm[4:0];
    id_rf_we = imm[0];
    id_mc    = m;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%0h exp=1", s1_ready); end
    checks++; if (s1_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", s1_valid); end
    checks++; if (s1_last !== 1'b1) begin errors++; $display("FAIL rst_last got=%0h exp=1", s1_last); end
    checks++; if (s1_phase !== 1'b0) begin errors++; $display("FAIL rst_phase got=%0h exp=0", s1_phase); end
    checks++; if (s1_op !== '0) begin errors++; $display("FAIL rst_op got=%0h exp=0", s1_op); end
    checks++; if (s1_imm21 !== '0) begin errors++; $display("FAIL rst_imm21 got=%0h exp=0", s1_imm21); end
    checks++; if (s0_valid !== 1'b0) begin errors++; $display("FAIL rst_valid0 got=%0h exp=0", s0_valid); end
    #10 rst_n = 1'b1;
    cyc();
    checks++; if (s1_valid !== 1'b0) begin errors++; $display("FAIL rst_rel_valid got=%0h exp=0", s1_valid); end
    checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL rst_rel_ready got=%0h exp=1", s1_ready); end
  endtask

  task automatic test_single();
    ex_ready = 1'b1;
    drive(1'b1, OP_CINC, 12'h7ff, 1'b0);
    #1;
    checks++; if (s1_valid !== 1'b0) begin errors++; $display("FAIL single_nobypass got=%0h exp=0", s1_valid); end
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    checks++; if (s1_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0h exp=1", s1_valid); end
    checks++; if (s1_imm12 !== 12'h7ff) begin errors++; $display("FAIL single_imm12 got=%0h exp=7ff", s1_imm12); end
    checks++; if (s1_op !== OP_CINC) begin errors++; $display("FAIL single_op got=%0h exp=%0h", s1_op, OP_CINC); end
    checks++; if (s1_imm20 !== 20'h7ffa5) begin errors++; $display("FAIL single_imm20 got=%0h exp=7ffa5", s1_imm20); end
    checks++; if (s1_imm21 !== 21'h0ffe01) begin errors++; $display("FAIL single_imm21 got=%0h exp=ffe01", s1_imm21); end
    checks++; if (s1_cs2 !== 5'h1f) begin errors++; $display("FAIL single_cs2 got=%0h exp=1f", s1_cs2); end
    checks++; if (s1_rf_we !== 1'b1) begin errors++; $display("FAIL single_rfwe got=%0h exp=1", s1_rf_we); end
    checks++; if (s1_last !== 1'b1) begin errors++; $display("FAIL single_last got=%0h exp=1", s1_last); end
    checks++; if (s1_phase !== 1'b0) begin errors++; $display("FAIL single_phase got=%0h exp=0", s1_phase); end
    checks++; if (s0_op !== OP_CINC) begin errors++; $display("FAIL single_op0 got=%0h exp=%0h", s0_op, OP_CINC); end
    checks++; if (s0_imm20 !== 20'h7ffa5) begin errors++; $display("FAIL single_imm20_0 got=%0h exp=7ffa5", s0_imm20); end
    checks++; if (s0_imm21 !== 21'h0ffe01) begin errors++; $display("FAIL single_imm21_0 got=%0h exp=ffe01", s0_imm21); end
    checks++; if (s0_cs2 !== 5'h1f) begin errors++; $display("FAIL single_cs2_0 got=%0h exp=1f", s0_cs2); end
    checks++; if (s0_rf_we !== 1'b1) begin errors++; $display("FAIL single_rfwe0 got=%0h exp=1", s0_rf_we); end
    cyc();
    checks++; if (s1_valid !== 1'b0) begin errors++; $display("FAIL single_once got=%0h exp=0", s1_valid); end
    checks++; if (s1_imm12 !== 12'h000) begin errors++; $display("FAIL single_zero_imm got=%0h exp=0", s1_imm12); end
    checks++; if (s1_op !== '0) begin errors++; $display("FAIL single_zero_op got=%0h exp=0", s1_op); end
    checks++; if (s1_rf_we !== 1'b0) begin errors++; $display("FAIL single_zero_we got=%0h exp=0", s1_rf_we); end
  endtask

  task automatic test_back_pressure();
    ex_ready = 1'b0;
    drive(1'b1, OP_CINC, 12'h0a1, 1'b0);
    cyc();
    drive(1'b1, OP_CINC, 12'h0b2, 1'b0);
    checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a got=%0h exp=1", s1_ready); end
    checks++; if (s1_imm12 !== 12'h0a1) begin errors++; $display("FAIL bp_head_a got=%0h exp=0a1", s1_imm12); end
    cyc();
    drive(1'b1, OP_CINC, 12'h0c3, 1'b0);
    checks++; if (s1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%0h exp=0", s1_ready); end
    checks++; if (s1_imm12 !== 12'h0a1) begin errors++; $display("FAIL bp_head_hold got=%0h exp=0a1", s1_imm12); end
    cyc();
    checks++; if (s1_ready !== 1'b0) begin errors++; $display("FAIL bp_c_held got=%0h exp=0", s1_ready); end
    checks++; if (s1_imm12 !== 12'h0a1) begin errors++; $display("FAIL bp_head_hold2 got=%0h exp=0a1", s1_imm12); end
    ex_ready = 1'b1;
    cyc();
    checks++; if (s1_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_b got=%0h exp=1", s1_valid); end
    checks++; if (s1_imm12 !== 12'h0b2) begin errors++; $display("FAIL bp_pop_b got=%0h exp=0b2", s1_imm12); end
    checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b got=%0h exp=1", s1_ready); end
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    checks++; if (s1_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_c got=%0h exp=1", s1_valid); end
    checks++; if (s1_imm12 !== 12'h0c3) begin errors++; $display("FAIL bp_pop_c got=%0h exp=0c3", s1_imm12); end
    cyc();
    checks++; if (s1_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%0h exp=0", s1_valid); end
  endtask

  task automatic test_multicycle();
    ex_ready = 1'b1;
    drive(1'b1, OP_CSB, 12'h111, 1'b1);
    cyc();
    drive(1'b1, OP_CINC, 12'h222, 1'b0);
    checks++; if (s1_imm12 !== 12'h111) begin errors++; $display("FAIL mc_c1_imm got=%0h exp=111", s1_imm12); end
    checks++; if (s1_phase !== 1'b0) begin errors++; $display("FAIL mc_c1_phase got=%0h exp=0", s1_phase); end
    checks++; if (s1_last !== 1'b0) begin errors++; $display("FAIL mc_c1_last got=%0h exp=0", s1_last); end
    checks++; if (s0_last !== 1'b1) begin errors++; $display("FAIL sc_c1_last got=%0h exp=1", s0_last); end
    checks++; if (s0_imm12 !== 12'h111) begin errors++; $display("FAIL sc_c1_imm got=%0h exp=111", s0_imm12); end
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    checks++; if (s1_imm12 !== 12'h111) begin errors++; $display("FAIL mc_c2_imm got=%0h exp=111", s1_imm12); end
    checks++; if (s1_phase !== 1'b1) begin errors++; $display("FAIL mc_c2_phase got=%0h exp=1", s1_phase); end
    checks++; if (s1_last !== 1'b1) begin errors++; $display("FAIL mc_c2_last got=%0h exp=1", s1_last); end
    checks++; if (s1_ready !== 1'b0) begin errors++; $display("FAIL mc_c2_ready got=%0h exp=0", s1_ready); end
    checks++; if (s0_imm12 !== 12'h222) begin errors++; $display("FAIL sc_c2_imm got=%0h exp=222", s0_imm12); end
    checks++; if (s0_phase !== 1'b0) begin errors++; $display("FAIL sc_c2_phase got=%0h exp=0", s0_phase); end
    cyc();
    checks++; if (s1_imm12 !== 12'h222) begin errors++; $display("FAIL mc_c3_imm got=%0h exp=222", s1_imm12); end
    checks++; if (s1_phase !== 1'b0) begin errors++; $display("FAIL mc_c3_phase got=%0h exp=0", s1_phase); end
    checks++; if (s1_last !== 1'b1) begin errors++; $display("FAIL mc_c3_last got=%0h exp=1", s1_last); end
    checks++; if (s0_valid !== 1'b0) begin errors++; $display("FAIL sc_c3_valid got=%0h exp=0", s0_valid); end
    cyc();
    checks++; if (s1_valid !== 1'b0) begin errors++; $display("FAIL mc_drained got=%0h exp=0", s1_valid); end
  endtask

  task automatic test_flush();
    // Flush in phase 0 together with an incoming op.
    ex_ready = 1'b1;
    drive(1'b1, OP_CSB, 12'h155, 1'b1);
    cyc();
    drive(1'b1, OP_CINC, 12'h166, 1'b0);
    flush = 1'b1;
    checks++; if (s1_last !== 1'b0) begin errors++; $display("FAIL fl_pre_last got=%0h exp=0", s1_last); end
    checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL fl_pre_ready got=%0h exp=1", s1_ready); end
    cyc();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    checks++; if (s1_valid !== 1'b0) begin errors++; $display("FAIL fl_a_valid got=%0h exp=0", s1_valid); end
    checks++; if (s1_phase !== 1'b0) begin errors++; $display("FAIL fl_a_phase got=%0h exp=0", s1_phase); end
    checks++; if (s1_op !== '0) begin errors++; $display("FAIL fl_a_op got=%0h exp=0", s1_op); end
    cyc();
    checks++; if (s1_valid !== 1'b0) begin errors++; $display("FAIL fl_a_dropped got=%0h exp=0", s1_valid); end
    // Flush with both entries valid, together with a pop and an incoming op.
    ex_ready = 1'b0;
    drive(1'b1, OP_CINC, 12'h1a1, 1'b0);
    cyc();
    drive(1'b1, OP_CINC, 12'h1b2, 1'b0);
    cyc();
    checks++; if (s1_ready !== 1'b0) begin errors++; $display("FAIL fl_b_full got=%0h exp=0", s1_ready); end
    drive(1'b1, OP_CINC, 12'h1c3, 1'b0);
    ex_ready = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    checks++; if (s1_valid !== 1'b0) begin errors++; $display("FAIL fl_b_valid got=%0h exp=0", s1_valid); end
    checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL fl_b_ready got=%0h exp=1", s1_ready); end
    cyc();
    checks++; if (s1_valid !== 1'b0) begin errors++; $display("FAIL fl_b_dropped got=%0h exp=0", s1_valid); end
    // Flush with a pop pending in phase 1.
    drive(1'b1, OP_CSB, 12'h1d4, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    cyc();
    checks++; if (s1_phase !== 1'b1) begin errors++; $display("FAIL fl_c_pre_phase got=%0h exp=1", s1_phase); end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    checks++; if (s1_phase !== 1'b0) begin errors++; $display("FAIL fl_c_phase got=%0h exp=0", s1_phase); end
    checks++; if (s1_valid !== 1'b0) begin errors++; $display("FAIL fl_c_valid got=%0h exp=0", s1_valid); end
  endtask

  task automatic test_async_reset();
    ex_ready = 1'b0;
    drive(1'b1, OP_CSB, 12'h333, 1'b1);
    cyc();
    drive(1'b1, OP_CINC, 12'h444, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    checks++; if (s1_ready !== 1'b0) begin errors++; $display("FAIL ar_pre_ready got=%0h exp=0", s1_ready); end
    checks++; if (s1_phase !== 1'b1) begin errors++; $display("FAIL ar_pre_phase got=%0h exp=1", s1_phase); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (s1_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got=%0h exp=0", s1_valid); end
    checks++; if (s1_ready !== 1'b1) begin errors++; $display("FAIL ar_ready got=%0h exp=1", s1_ready); end
    checks++; if (s1_phase !== 1'b0) begin errors++; $display("FAIL ar_phase got=%0h exp=0", s1_phase); end
    checks++; if (s1_last !== 1'b1) begin errors++; $display("FAIL ar_last got=%0h exp=1", s1_last); end
    checks++; if (s1_imm12 !== 12'h000) begin errors++; $display("FAIL ar_imm12 got=%0h exp=0", s1_imm12); end
    checks++; if (s1_op !== '0) begin errors++; $display("FAIL ar_op got=%0h exp=0", s1_op); end
    checks++; if (s0_valid !== 1'b0) begin errors++; $display("FAIL ar_valid0 got=%0h exp=0", s0_valid); end
    checks++; if (s0_ready !== 1'b1) begin errors++; $display("FAIL ar_ready0 got=%0h exp=1", s0_ready); end
    #2 rst_n = 1'b1;
    cyc();
    checks++; if (s1_valid !== 1'b0) begin errors++; $display("FAIL ar_after got=%0h exp=0", s1_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_pressure();
    test_multicycle();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
